mc_fetch_seq: RTL

MC_FETCH_SEQ -- requirements
Module: mc_fetch_seq

---
 rtl/mc_pkg.sv | 33 +++
 rtl/mc_en_reg.sv | 25 ++
 rtl/mc_fetch_seq.sv | 106 ++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// ---------------------------------------------------------------
// mc_pkg: shared encodings for the multicycle fetch sequencer
// rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package mc_pkg;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXEC    = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_JUMP    = 4'd9;
  localparam logic [3:0] S_LAST    = S_JUMP;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mc_en_reg.sv
// ---------------------------------------------------------------
// mc_en_reg: width-parameterised register, sync reset value, load enable
// rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module mc_en_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= RESET_VAL;
    else if (en) q <= d;
  end

endmodule

`default_nettype wire

// File: rtl/mc_fetch_seq.sv
// ---------------------------------------------------------------
// mc_fetch_seq: state/PC/IR/MDR holding and memory handshake for a multicycle CPU
// rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module mc_fetch_seq
  import mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ns,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic        iord,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        ir_write,
  input  logic [1:0]  pc_source,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_out,
  input  logic        zero,
  input  logic [31:0] b_data,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [3:0]  state,
  output logic [5:0]  opcode,
  output logic [31:0] ir,
  output logic [31:0] mdr,
  output logic [31:0] pc,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  output logic        stall,
  output logic        illegal_state
);

  logic [3:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, mdr_q;
  logic        illegal_q;
  logic        state_en, pc_en, ir_en, mdr_en, illegal_en;
  logic        ns_bad, read_done;

  always_comb begin
    stall     = (mem_read | mem_write) & ~mem_ready;
    ns_bad    = (ns > S_LAST);
    read_done = mem_read & mem_ready;

    state_en   = ~stall;
    state_d    = ns_bad ? S_FETCH : ns;
    illegal_en = ~stall & ns_bad;

    // PCS 11 is a hold, so it suppresses the load rather than feeding pc back
    pc_en = ~stall & (pc_write | (pc_write_cond & zero)) & (pc_source != 2'b11);
    case (pc_source)
      PCS_ALU:    pc_d = alu_result;
      PCS_ALUOUT: pc_d = alu_out;
      PCS_JUMP:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
      default:    pc_d = pc_q;
    endcase

    ir_en  = ir_write & read_done;
    mdr_en = read_done;
  end

  mc_en_reg #(.WIDTH(4), .RESET_VAL(S_FETCH)) u_state (
    .clk(clk), .reset(reset), .en(state_en), .d(state_d), .q(state_q)
  );

  mc_en_reg #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_pc (
    .clk(clk), .reset(reset), .en(pc_en), .d(pc_d), .q(pc_q)
  );

  mc_en_reg #(.WIDTH(32), .RESET_VAL(32'h0)) u_ir (
    .clk(clk), .reset(reset), .en(ir_en), .d(mem_rdata), .q(ir_q)
  );

  mc_en_reg #(.WIDTH(32), .RESET_VAL(32'h0)) u_mdr (
    .clk(clk), .reset(reset), .en(mdr_en), .d(mem_rdata), .q(mdr_q)
  );

  mc_en_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_illegal (
    .clk(clk), .reset(reset), .en(illegal_en), .d(1'b1), .q(illegal_q)
  );

  // mem_addr is stable across a stall because pc is frozen while stalled
  always_comb begin
    state         = state_q;
    pc            = pc_q;
    ir            = ir_q;
    mdr           = mdr_q;
    opcode        = ir_q[31:26];
    illegal_state = illegal_q;
    mem_addr      = iord ? alu_out : pc_q;
    mem_wdata     = b_data;
    mem_re        = mem_read;
    mem_we        = mem_write;
  end

endmodule

`default_nettype wire
